vx_l1_mem_arbiter: RTL
======================

# vx_l1_mem_arbiter

Round-robin arbiter that shares the core's single L1-to-memory port between NUM_REQS requesters, default icache (index 0) and dcache (index 1). It sits between the L1 caches' memory-side interfaces and the core's mem_req/mem_rsp ports. It tags each request with the requester index and routes responses back by that index. It also bounds outstanding reads and reports memory-side busy status.

## Interface
- NUM_REQS, 2: number of requesters, ≥2. LOG_NUM_REQS = clog2(NUM_REQS).
- DATA_WIDTH, 512: memory data width in bits. BYTEEN_WIDTH = DATA_WIDTH/8.
- ADDR_WIDTH, 26: memory line address width.
- TAG_IN_WIDTH, 8: requester tag width. TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS.
- MAX_PENDING, 16: maximum outstanding reads, ≥1. Counter width PW = clog2(MAX_PENDING+1).

Ports. Per-requester buses are packed, with requester i in slice i.
- clk  in  1  clock; all logic rises on posedge.
- reset  in  1  synchronous, active-high.
- req_valid_in  in  NUM_REQS  per-requester request valid.
- req_rw_in  in  NUM_REQS  1 = write.
- req_byteen_in  in  NUM_REQS*BYTEEN_WIDTH  write byte enables.
- req_addr_in  in  NUM_REQS*ADDR_WIDTH  line address.
- req_data_in  in  NUM_REQS*DATA_WIDTH  write data.
- req_tag_in  in  NUM_REQS*TAG_IN_WIDTH  requester tag.
- req_ready_out  out  NUM_REQS  per-requester accept.
- mem_req_valid  out  1  memory request valid.
- mem_req_rw, mem_req_byteen, mem_req_addr, mem_req_data  out  1/BYTEEN_WIDTH/ADDR_WIDTH/DATA_WIDTH  selected request fields.
- mem_req_tag  out  TAG_OUT_WIDTH  {tag_in, index}; index occupies the LSBs.
- mem_req_ready  in  1  memory accepts.
- mem_rsp_valid  in  1  response valid.
- mem_rsp_data  in  DATA_WIDTH  response data.
- mem_rsp_tag  in  TAG_OUT_WIDTH  response tag.
- mem_rsp_ready  out  1  response accept.
- rsp_valid_out  out  NUM_REQS  one-hot response valid.
- rsp_data_out  out  DATA_WIDTH  broadcast response data.
- rsp_tag_out  out  TAG_IN_WIDTH  mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_NUM_REQS].
- rsp_ready_in  in  NUM_REQS  per-requester response accept.
- pending_count  out  PW  outstanding reads.
- busy  out  1  pending_count≠0 or output register valid.

## Operation
- Request output register: one entry holding valid plus all mem_req fields. can_load = !out_valid | mem_req_ready.
- Read gate: read_ok = pending_count < MAX_PENDING. A requester is eligible if req_valid_in[i] & (req_rw_in[i] | read_ok).
- Round-robin: pointer rr_ptr. The grant goes to the first eligible index scanning rr_ptr, rr_ptr+1, … mod NUM_REQS.
- Grant occurs only when can_load. At most one req_ready_out bit is high per cycle, and only for the granted requester. req_ready_out never depends on that requester's own valid being high beyond eligibility (no combinational loop through ready).
- On grant to g: load the register, and set rr_ptr = (g+1) mod NUM_REQS. With no grant, rr_ptr holds.
- If can_load and nothing is granted, out_valid clears once the held request fires.
- Pending counter: +1 when a read is granted (grant time, not memory acceptance). −1 on mem_rsp_valid & mem_rsp_ready. If both occur in the same cycle, the count is unchanged. Overflow and underflow are impossible by construction and are checked by assertion.
- Response routing is combinational: idx = mem_rsp_tag[LOG_NUM_REQS-1:0]. rsp_valid_out = mem_rsp_valid << idx. mem_rsp_ready = rsp_ready_in[idx]. An idx ≥ NUM_REQS is a fatal assertion.
- Writes never produce a response and never touch the counter.

## Timing
- Reset values: out_valid=0, mem_req_valid=0, rr_ptr=0, pending_count=0, busy=0. req_ready_out=0 during reset.
- Reset mid-operation drops the held request and zeroes the counter. Responses arriving after reset are the environment's responsibility.
- Request latency: granted in cycle N, mem_req_valid high in N+1.
- Throughput: 1 request/cycle when mem_req_ready is held high.
- Fields are stable while mem_req_valid=1 and mem_req_ready=0.
- Response path: 0-cycle latency, no storage.
- Read gate at the limit: when pending_count==MAX_PENDING and a response fires in cycle N, a new read can be granted in N+1, not in N.
- Under continuous contention, each requester waits at most NUM_REQS−1 grants.

## Test plan
- Reset, then idle → all outputs 0, busy=0. A single icache read, addr 0x100, tag 0x05 → mem_req_valid next cycle, mem_req_tag=0x0A (binary 0000_1010).
- Icache and dcache both valid continuously, mem_req_ready=1 → grants alternate 0,1,0,1. The first grant goes to 0 after reset.
- mem_req_ready=0 for 5 cycles with a request held → mem_req fields stable, req_ready_out=0 for both. On release, the next grant follows in the same cycle.
- MAX_PENDING=2: issue 3 dcache reads with no response → the third is stalled, pending_count=2. A write from icache is still granted. One response → the third read is granted the next cycle.
- Response tag 0x0B with rsp_ready_in=2'b10 → rsp_valid_out=2'b10, rsp_tag_out=0x05, mem_rsp_ready=1. With rsp_ready_in=2'b01 → mem_rsp_ready=0.
- A read grant and a response fire in the same cycle at pending_count=1 → count stays 1. Assert reset mid-burst → count=0, mem_req_valid=0 next cycle.

Source files
------------

// File: rtl/vx_l1_mem_arbiter.sv
// vx_l1_mem_arbiter
// Shares one L1-to-memory port between NUM_REQS requesters, by round robin.
// Index 0 is the icache and index 1 the dcache by default. Each forwarded
// request carries the requester index in the low bits of its tag, and each
// response is routed back to a requester by those bits. The block also limits
// the number of outstanding reads and reports whether the memory side is busy.
//
// Ports (per-requester buses are packed; requester i uses slice i):
//   clk, reset                  clock; synchronous active-high reset
//   req_*_in / req_ready_out    requester-side request handshake and fields
//   mem_req_* (out) / mem_req_ready (in)
//                               registered memory request; tag = {tag_in, index}
//   mem_rsp_* (in) / mem_rsp_ready (out)
//                               memory response, passed through with no storage
//   rsp_valid_out / rsp_data_out / rsp_tag_out / rsp_ready_in
//                               requester-side response, steered by tag index
//   pending_count               number of outstanding reads
//   busy                        high while reads are outstanding or a request is held
module vx_l1_mem_arbiter #(
  parameter int NUM_REQS      = 2,
  parameter int DATA_WIDTH    = 512,
  parameter int ADDR_WIDTH    = 26,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int MAX_PENDING   = 16,
  localparam int LOG_NUM_REQS  = $clog2(NUM_REQS),
  localparam int BYTEEN_WIDTH  = DATA_WIDTH / 8,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS,
  localparam int PW            = $clog2(MAX_PENDING + 1)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               req_valid_in,
  input  logic [NUM_REQS-1:0]               req_rw_in,
  input  logic [NUM_REQS*BYTEEN_WIDTH-1:0]  req_byteen_in,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr_in,
  input  logic [NUM_REQS*DATA_WIDTH-1:0]    req_data_in,
  input  logic [NUM_REQS*TAG_IN_WIDTH-1:0]  req_tag_in,
  output logic [NUM_REQS-1:0]               req_ready_out,
  output logic                              mem_req_valid,
  output logic                              mem_req_rw,
  output logic [BYTEEN_WIDTH-1:0]           mem_req_byteen,
  output logic [ADDR_WIDTH-1:0]             mem_req_addr,
  output logic [DATA_WIDTH-1:0]             mem_req_data,
  output logic [TAG_OUT_WIDTH-1:0]          mem_req_tag,
  input  logic                              mem_req_ready,
  input  logic                              mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]             mem_rsp_data,
  input  logic [TAG_OUT_WIDTH-1:0]          mem_rsp_tag,
  output logic                              mem_rsp_ready,
  output logic [NUM_REQS-1:0]               rsp_valid_out,
  output logic [DATA_WIDTH-1:0]             rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]           rsp_tag_out,
  input  logic [NUM_REQS-1:0]               rsp_ready_in,
  output logic [PW-1:0]                     pending_count,
  output logic                              busy
);

  logic                     out_valid_q;
  logic                     out_rw_q;
  logic [BYTEEN_WIDTH-1:0]  out_byteen_q;
  logic [ADDR_WIDTH-1:0]    out_addr_q;
  logic [DATA_WIDTH-1:0]    out_data_q;
  logic [TAG_OUT_WIDTH-1:0] out_tag_q;

  logic [LOG_NUM_REQS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]            pending_q, pending_d;

  logic                     can_load;
  logic                     read_ok;
  logic [NUM_REQS-1:0]      eligible;
  logic                     gnt_valid;
  logic [LOG_NUM_REQS-1:0]  gnt_idx;
  logic [LOG_NUM_REQS-1:0]  cand_idx;
  int unsigned              cand;
  logic                     rd_inc;
  logic                     rsp_fire;
  logic [LOG_NUM_REQS-1:0]  rsp_idx;

  // Grant selection: first eligible requester scanning from rr_ptr upwards.
  // Ready is simply the grant, so it depends on a requester's valid only
  // through eligibility and never loops back through the requester.
  always_comb begin
    can_load  = !out_valid_q || mem_req_ready;
    read_ok   = pending_q < PW'(MAX_PENDING);
    eligible  = req_valid_in & (req_rw_in | {NUM_REQS{read_ok}});
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    if (can_load && !reset) begin
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
        cand     = (int'(rr_ptr_q) + k) % NUM_REQS;
        cand_idx = LOG_NUM_REQS'(cand);
        if (!gnt_valid && eligible[cand_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
    req_ready_out = gnt_valid ? (NUM_REQS'(1) << gnt_idx) : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_valid) begin
      rr_ptr_d = (int'(gnt_idx) == NUM_REQS - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Reads are counted when granted, not when memory accepts them, so the
  // read gate already accounts for a read sitting in the output register.
  always_comb begin
    rd_inc    = gnt_valid && !req_rw_in[gnt_idx];
    rsp_fire  = mem_rsp_valid && mem_rsp_ready;
    pending_d = pending_q;
    case ({rd_inc, rsp_fire})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      pending_q   <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      pending_q <= pending_d;
      if (can_load) begin
        out_valid_q <= gnt_valid;
      end
    end
  end

  // Payload needs no reset: it is only observed while out_valid_q is set.
  always_ff @(posedge clk) begin
    if (gnt_valid) begin
      out_rw_q     <= req_rw_in[gnt_idx];
      out_byteen_q <= req_byteen_in[gnt_idx*BYTEEN_WIDTH +: BYTEEN_WIDTH];
      out_addr_q   <= req_addr_in[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      out_data_q   <= req_data_in[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      out_tag_q    <= {req_tag_in[gnt_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH], gnt_idx};
    end
  end

  assign mem_req_valid  = out_valid_q;
  assign mem_req_rw     = out_rw_q;
  assign mem_req_byteen = out_byteen_q;
  assign mem_req_addr   = out_addr_q;
  assign mem_req_data   = out_data_q;
  assign mem_req_tag    = out_tag_q;

  // Response path is purely combinational.
  assign rsp_idx       = mem_rsp_tag[LOG_NUM_REQS-1:0];
  assign rsp_tag_out   = mem_rsp_tag[TAG_OUT_WIDTH-1:LOG_NUM_REQS];
  assign rsp_data_out  = mem_rsp_data;
  assign rsp_valid_out = NUM_REQS'(mem_rsp_valid) << rsp_idx;
  assign mem_rsp_ready = (int'(rsp_idx) < NUM_REQS) ? rsp_ready_in[rsp_idx] : 1'b0;

  assign pending_count = pending_q;
  assign busy          = (pending_q != '0) || out_valid_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (mem_rsp_valid) begin
        assert (int'(rsp_idx) < NUM_REQS)
          else $fatal(1, "response tag index out of range");
      end
      assert (!(rsp_fire && !rd_inc && pending_q == '0))
        else $error("pending counter underflow");
      assert (!(rd_inc && !rsp_fire && pending_q == PW'(MAX_PENDING)))
        else $error("pending counter overflow");
    end
  end
`endif

endmodule
